// File: rtl/spi_slave_core.sv
// spi_slave_core
// SPI slave that runs entirely on the system clock. The sclk, mosi and cs_n
// pins are oversampled through synchronisers, so sclk must stay at or below
// clk/4. The core supports all four SPI modes, a configurable word width and
// bit order, and multi-word frames. A one-deep transmit holding buffer feeds
// the outgoing shift word.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   sclk          SPI serial clock (asynchronous, oversampled)
//   mosi          SPI data in
//   cs_n          SPI chip select, active low
//   miso          SPI data out (0 while not driven)
//   miso_oe       miso output enable, high while the frame is active
//   tx_data       word offered for transmission
//   tx_valid      tx_data valid
//   tx_ready      holding buffer empty
//   rx_data       last complete received word
//   rx_valid      one-cycle strobe, rx_data updated
//   tx_underrun   one-cycle pulse, a word was loaded with nothing to send
//   frame_abort   one-cycle pulse, cs_n rose in the middle of a word
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic            IDLE_LVL = (CPOL != 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      rx_shift;
  logic [DATA_W-1:0]      tx_shift;
  logic [DATA_W-1:0]      hold_data;
  logic                   hold_full;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sample_edge;
  logic                   cs_fall;
  logic                   cs_rise;
  logic [DATA_W-1:0]      rx_next;
  logic [DATA_W-1:0]      tx_shifted;
  logic                   tx_next_bit;
  logic [DATA_W-1:0]      load_word;
  logic                   load_empty;
  logic                   load_point;

  // The pins share one synchroniser depth, so a mosi bit and the sclk edge
  // that samples it stay aligned. The extra sclk_d/cs_d copies feed the edge
  // detectors below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
      cs_sync   <= {SYNC_STAGES{1'b1}};
      mosi_sync <= '0;
      sclk_d    <= IDLE_LVL;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_d == IDLE_LVL) && (sclk_s != IDLE_LVL);
  assign trail_edge  = (sclk_d != IDLE_LVL) && (sclk_s == IDLE_LVL);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign cs_fall     = cs_d && !cs_s;
  assign cs_rise     = !cs_d && cs_s;
  assign tx_ready    = !hold_full;

  // Next-word selection, plus the shift datapaths in the configured bit
  // order. At a load point a full holding buffer takes priority. An empty
  // buffer lets a word offered in the same cycle bypass straight into the
  // shift word. With neither available, zeros are sent and the load is
  // flagged as an underrun.
  always_comb begin
    rx_next     = '0;
    tx_shifted  = '0;
    tx_next_bit = 1'b0;
    load_word   = '0;
    load_empty  = 1'b0;
    if (MSB_FIRST != 0) begin
      rx_next     = {rx_shift[DATA_W-2:0], mosi_s};
      tx_shifted  = {tx_shift[DATA_W-2:0], 1'b0};
      tx_next_bit = tx_shift[DATA_W-2];
    end else begin
      rx_next     = {mosi_s, rx_shift[DATA_W-1:1]};
      tx_shifted  = {1'b0, tx_shift[DATA_W-1:1]};
      tx_next_bit = tx_shift[1];
    end
    if (hold_full) begin
      load_word = hold_data;
    end else if (tx_valid) begin
      load_word = tx_data;
    end else begin
      load_empty = 1'b1;
    end
    load_point = ((state == IDLE) && cs_fall) ||
                 ((state == ACTIVE) && !cs_rise && sample_edge && (bit_cnt == LAST_BIT));
  end

  // Frame control, receive shifting and transmit loading. cs_n rising takes
  // priority over a sample edge in the same cycle. Every load point empties
  // the holding buffer. Either its word was consumed, or a bypassed word was
  // never stored in it, which overrides the accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end

      case (state)
        IDLE: begin
          miso_oe <= 1'b0;
          miso    <= 1'b0;
          bit_cnt <= '0;
          if (cs_fall) begin
            state    <= ACTIVE;
            miso_oe  <= 1'b1;
            rx_shift <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
            if (bit_cnt != '0) begin
              frame_abort <= 1'b1;
            end
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            tx_shift <= tx_shifted;
            miso     <= tx_next_bit;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load_point) begin
        tx_shift    <= load_word;
        miso        <= (MSB_FIRST != 0) ? load_word[DATA_W-1] : load_word[0];
        tx_underrun <= load_empty;
        hold_full   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core
// Directed bench for spi_slave_core. It drives three instances:
//   dut0  mode 0, 8-bit, MSB first
//   dut1  mode 3, 8-bit, MSB first
//   dut2  mode 1, 16-bit, LSB first
// Each instance has its own sclk/cs_n/tx_valid, and all share mosi and
// tx_data. A bit-banged master runs at 80 ns per sclk period (clk/8).
module tb_spi_slave_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sclk_v = 3'b010;
  logic [2:0]  cs_v = 3'b111;
  logic [2:0]  tx_valid_v = 3'b000;
  logic        mosi = 1'b0;
  logic [15:0] tx_data = 16'h0000;

  logic [2:0]  miso_v;
  logic [2:0]  oe_v;
  logic [2:0]  tx_ready_v;
  logic [2:0]  rx_valid_v;
  logic [2:0]  und_v;
  logic [2:0]  abort_v;
  logic [7:0]  rx_data0;
  logic [7:0]  rx_data1;
  logic [15:0] rx_data2;

  int          checks = 0;
  int          errors = 0;
  int          rxcnt[3] = '{0, 0, 0};
  int          undcnt[3] = '{0, 0, 0};
  int          abcnt[3] = '{0, 0, 0};
  logic [7:0]  rx1_q[$];

  logic [15:0] r;
  logic [15:0] r1;
  logic [15:0] r2;
  int          rx_base;
  int          und_base;
  int          ab_base;
  int          q_base;

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]), .mosi(mosi), .cs_n(cs_v[0]),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_v[0]), .rx_data(rx_data0), .rx_valid(rx_valid_v[0]),
    .tx_underrun(und_v[0]), .frame_abort(abort_v[0])
  );

  spi_slave_core #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]), .mosi(mosi), .cs_n(cs_v[1]),
    .miso(miso_v[1]), .miso_oe(oe_v[1]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_v[1]), .rx_data(rx_data1), .rx_valid(rx_valid_v[1]),
    .tx_underrun(und_v[1]), .frame_abort(abort_v[1])
  );

  spi_slave_core #(.DATA_W(16), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .sclk(sclk_v[2]), .mosi(mosi), .cs_n(cs_v[2]),
    .miso(miso_v[2]), .miso_oe(oe_v[2]), .tx_data(tx_data), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready_v[2]), .rx_data(rx_data2), .rx_valid(rx_valid_v[2]),
    .tx_underrun(und_v[2]), .frame_abort(abort_v[2])
  );

  // Pulse counters, sampled on the falling clock edge so each one-cycle
  // pulse is seen exactly once.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid_v[i] === 1'b1) rxcnt[i]++;
      if (und_v[i] === 1'b1) undcnt[i]++;
      if (abort_v[i] === 1'b1) abcnt[i]++;
    end
    if (rx_valid_v[1] === 1'b1) rx1_q.push_back(rx_data1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Master side of one word (or of a partial word when nbits < width).
  // It samples miso just before its own sample edge.
  task automatic applyStimulus(input int inst, input logic [15:0] txw, input int nbits,
                               output logic [15:0] rxw);
    logic cpol;
    int   cpha;
    int   width;
    int   msb;
    int   idx;
    case (inst)
      0:       begin cpol = 1'b0; cpha = 0; width = 8;  msb = 1; end
      1:       begin cpol = 1'b1; cpha = 1; width = 8;  msb = 1; end
      default: begin cpol = 1'b0; cpha = 1; width = 16; msb = 0; end
    endcase
    rxw = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = (msb != 0) ? (width - 1 - i) : i;
      if (cpha == 0) begin
        mosi = txw[idx];
        #40;
        rxw[idx] = miso_v[inst];
        sclk_v[inst] = ~cpol;
        #40;
        sclk_v[inst] = cpol;
      end else begin
        sclk_v[inst] = ~cpol;
        mosi = txw[idx];
        #40;
        rxw[idx] = miso_v[inst];
        sclk_v[inst] = cpol;
        #40;
      end
    end
  endtask

  task automatic csLow(input int inst);
    cs_v[inst] = 1'b0;
    #80;
  endtask

  task automatic csHigh(input int inst);
    #80;
    cs_v[inst] = 1'b1;
    #80;
  endtask

  task automatic offerTx(input int inst, input logic [15:0] data);
    @(negedge clk);
    tx_data = data;
    tx_valid_v[inst] = 1'b1;
    @(negedge clk);
    tx_valid_v[inst] = 1'b0;
  endtask

  initial begin
    #20;
    checkOutput("reset_miso", {31'd0, miso_v[0]}, 32'd0);
    checkOutput("reset_miso_oe", {31'd0, oe_v[0]}, 32'd0);
    checkOutput("reset_tx_ready", {31'd0, tx_ready_v[0]}, 32'd1);
    checkOutput("reset_rx_data", {24'd0, rx_data0}, 32'd0);
    checkOutput("reset_pulses", {29'd0, rx_valid_v[0], und_v[0], abort_v[0]}, 32'd0);
    rst = 1'b0;
    #40;

    $display("[TB] mode 0 single word");
    offerTx(0, 16'h00A5);
    checkOutput("t1_tx_ready_full", {31'd0, tx_ready_v[0]}, 32'd0);
    rx_base = rxcnt[0];
    ab_base = abcnt[0];
    csLow(0);
    checkOutput("t1_tx_ready_after_cs", {31'd0, tx_ready_v[0]}, 32'd1);
    checkOutput("t1_miso_oe_active", {31'd0, oe_v[0]}, 32'd1);
    applyStimulus(0, 16'h003C, 8, r);
    csHigh(0);
    checkOutput("t1_master_rx", {16'd0, r}, 32'h00A5);
    checkOutput("t1_rx_data", {24'd0, rx_data0}, 32'h3C);
    checkOutput("t1_rx_valid_count", rxcnt[0] - rx_base, 32'd1);
    checkOutput("t1_no_abort", abcnt[0] - ab_base, 32'd0);
    checkOutput("t1_miso_oe_idle", {31'd0, oe_v[0]}, 32'd0);

    $display("[TB] mode 3 two-word frame");
    und_base = undcnt[1];
    rx_base = rxcnt[1];
    q_base = rx1_q.size();
    offerTx(1, 16'h0012);
    csLow(1);
    fork
      applyStimulus(1, 16'h00F0, 8, r1);
      begin #200; offerTx(1, 16'h0034); end
    join
    fork
      applyStimulus(1, 16'h000F, 8, r2);
      begin #200; offerTx(1, 16'h0056); end
    join
    csHigh(1);
    checkOutput("t2_master_rx_w1", {16'd0, r1}, 32'h12);
    checkOutput("t2_master_rx_w2", {16'd0, r2}, 32'h34);
    checkOutput("t2_rx_valid_count", rxcnt[1] - rx_base, 32'd2);
    checkOutput("t2_rx_word1", {24'd0, rx1_q[q_base]}, 32'hF0);
    checkOutput("t2_rx_word2", {24'd0, rx1_q[q_base + 1]}, 32'h0F);
    checkOutput("t2_no_underrun", undcnt[1] - und_base, 32'd0);

    $display("[TB] mode 1 16-bit LSB first");
    offerTx(2, 16'h8001);
    csLow(2);
    applyStimulus(2, 16'h00FF, 16, r);
    csHigh(2);
    checkOutput("t3_master_rx", {16'd0, r}, 32'h8001);
    checkOutput("t3_rx_data", {16'd0, rx_data2}, 32'h00FF);

    $display("[TB] underrun at frame start");
    und_base = undcnt[0];
    csLow(0);
    checkOutput("t4_underrun_count", undcnt[0] - und_base, 32'd1);
    applyStimulus(0, 16'h00C6, 8, r);
    csHigh(0);
    checkOutput("t4_master_rx_zero", {16'd0, r}, 32'h00);
    checkOutput("t4_rx_data", {24'd0, rx_data0}, 32'hC6);

    $display("[TB] aborted frame then clean frame");
    ab_base = abcnt[0];
    rx_base = rxcnt[0];
    csLow(0);
    applyStimulus(0, 16'h00FF, 5, r);
    csHigh(0);
    checkOutput("t5_abort_count", abcnt[0] - ab_base, 32'd1);
    checkOutput("t5_no_rx_valid_partial", rxcnt[0] - rx_base, 32'd0);
    csLow(0);
    applyStimulus(0, 16'h0077, 8, r);
    csHigh(0);
    checkOutput("t5_rx_data", {24'd0, rx_data0}, 32'h77);
    checkOutput("t5_rx_valid_count", rxcnt[0] - rx_base, 32'd1);
    checkOutput("t5_abort_once", abcnt[0] - ab_base, 32'd1);

    $display("[TB] reset mid-frame");
    offerTx(0, 16'h00C3);
    csLow(0);
    offerTx(0, 16'h005A);
    applyStimulus(0, 16'h00FF, 3, r);
    rst = 1'b1;
    #20;
    checkOutput("t6_rst_miso", {31'd0, miso_v[0]}, 32'd0);
    checkOutput("t6_rst_miso_oe", {31'd0, oe_v[0]}, 32'd0);
    checkOutput("t6_rst_tx_ready", {31'd0, tx_ready_v[0]}, 32'd1);
    checkOutput("t6_rst_rx_data", {24'd0, rx_data0}, 32'd0);
    checkOutput("t6_rst_pulses", {29'd0, rx_valid_v[0], und_v[0], abort_v[0]}, 32'd0);
    cs_v[0] = 1'b1;
    #40;
    rst = 1'b0;
    #40;
    checkOutput("t6_tx_ready_after_rst", {31'd0, tx_ready_v[0]}, 32'd1);
    und_base = undcnt[0];
    csLow(0);
    checkOutput("t6_underrun_count", undcnt[0] - und_base, 32'd1);
    applyStimulus(0, 16'h0096, 8, r);
    csHigh(0);
    checkOutput("t6_master_rx_zero", {16'd0, r}, 32'h00);
    checkOutput("t6_rx_data", {24'd0, rx_data0}, 32'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
